// File: rtl/pwm_sched_if.sv
// Control and result bundle between the GPIO side (master) and the PWM
// measurement scheduler (slave).
interface pwm_sched_if #(
  parameter int CW = 32
);
  logic          start;
  logic [2:0]    chan_en;
  logic          busy;
  logic          done;
  logic [CW-1:0] red_high;
  logic [CW-1:0] red_low;
  logic [CW-1:0] green_high;
  logic [CW-1:0] green_low;
  logic [CW-1:0] blue_high;
  logic [CW-1:0] blue_low;
  logic [2:0]    timeout_flags;

  modport master (
    output start, chan_en,
    input  busy, done, red_high, red_low, green_high, green_low,
           blue_high, blue_low, timeout_flags
  );

  modport slave (
    input  start, chan_en,
    output busy, done, red_high, red_low, green_high, green_low,
           blue_high, blue_low, timeout_flags
  );
endinterface

// File: rtl/pwm_sched.sv
// Time-shares one edge-measurement engine over the red/green/blue PWM inputs,
// averaging high/low durations over NUM_PERIODS periods with a per-channel watchdog.
//
// state   | meaning
// IDLE    | waiting for start
// SELECT  | phase 0 picks next enabled channel, phase 1 lets the mux settle
// ARM     | waiting for the first rising edge of the selected input
// MEASURE | accumulating high/low segment lengths
// STORE   | publishing the averaged result for the channel
// DONE    | one-cycle done pulse
module pwm_sched #(
  parameter int NUM_PERIODS = 4,
  parameter int TIMEOUT     = 5000000,
  parameter int CW          = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       red,
  input  logic       green,
  input  logic       blue,
  pwm_sched_if.slave bus
);

  localparam int SH = $clog2(NUM_PERIODS);
  localparam int AW = CW + 6;
  localparam int PW = SH + 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WD_LOAD = WW'(TIMEOUT - 1);
  localparam logic [PW-1:0] P_LAST  = PW'(NUM_PERIODS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_ARM, S_MEASURE, S_STORE, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic          prev_q, prev_d;
  logic [2:0]    en_q, en_d;
  logic [1:0]    idx_q, idx_d;
  logic          sel_ph_q, sel_ph_d;
  logic [AW-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [CW-1:0] seg_q, seg_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [CW-1:0] res_hi_q [3];
  logic [CW-1:0] res_hi_d [3];
  logic [CW-1:0] res_lo_q [3];
  logic [CW-1:0] res_lo_d [3];
  logic [2:0]    to_q, to_d;

  logic          sel_in, rise, fall, wd_exp, nxt_found;
  logic [1:0]    nxt_idx;

  always_comb begin
    case (idx_q)
      2'd0:    sel_in = sync2_q[0];
      2'd1:    sel_in = sync2_q[1];
      2'd2:    sel_in = sync2_q[2];
      default: sel_in = 1'b0;
    endcase
  end

  assign rise   = sel_in & ~prev_q;
  assign fall   = ~sel_in & prev_q;
  assign wd_exp = (wd_q == '0) && !(rise || fall);

  // Lowest enabled channel at or above the current index.
  always_comb begin
    nxt_found = 1'b0;
    nxt_idx   = 2'd3;
    for (int i = 2; i >= 0; i--) begin
      if (en_q[i] && (i >= int'(idx_q))) begin
        nxt_found = 1'b1;
        nxt_idx   = 2'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= 1'b0;
      en_q     <= '0;
      idx_q    <= '0;
      sel_ph_q <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      seg_q    <= '0;
      pcnt_q   <= '0;
      wd_q     <= '0;
      to_q     <= '0;
      for (int i = 0; i < 3; i++) begin
        res_hi_q[i] <= '0;
        res_lo_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      en_q     <= en_d;
      idx_q    <= idx_d;
      sel_ph_q <= sel_ph_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      seg_q    <= seg_d;
      pcnt_q   <= pcnt_d;
      wd_q     <= wd_d;
      to_q     <= to_d;
      for (int i = 0; i < 3; i++) begin
        res_hi_q[i] <= res_hi_d[i];
        res_lo_q[i] <= res_lo_d[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (bus.start) state_d = S_SELECT;
      S_SELECT:  begin
        if (sel_ph_q)        state_d = S_ARM;
        else if (!nxt_found) state_d = S_DONE;
      end
      S_ARM:     begin
        if (wd_exp)    state_d = S_SELECT;
        else if (rise) state_d = S_MEASURE;
      end
      S_MEASURE: begin
        if (wd_exp)                           state_d = S_SELECT;
        else if (rise && (pcnt_q == P_LAST))  state_d = S_STORE;
      end
      S_STORE:   state_d = S_SELECT;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sync1_d  = {blue, green, red};
    sync2_d  = sync1_q;
    prev_d   = sel_in;
    en_d     = en_q;
    idx_d    = idx_q;
    sel_ph_d = sel_ph_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    seg_d    = seg_q;
    pcnt_d   = pcnt_q;
    wd_d     = wd_q;
    to_d     = to_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          en_d     = bus.chan_en;
          to_d     = '0;
          idx_d    = '0;
          sel_ph_d = 1'b0;
        end
      end
      S_SELECT: begin
        acc_hi_d = '0;
        acc_lo_d = '0;
        seg_d    = '0;
        pcnt_d   = '0;
        wd_d     = WD_LOAD;
        if (!sel_ph_q) begin
          if (nxt_found) begin
            idx_d    = nxt_idx;
            sel_ph_d = 1'b1;
          end
        end else begin
          sel_ph_d = 1'b0;
        end
      end
      S_ARM, S_MEASURE: begin
        wd_d = (rise || fall) ? WD_LOAD : wd_q - 1'b1;
        if (wd_exp) begin
          for (int i = 0; i < 3; i++) begin
            if (idx_q == 2'(i)) begin
              res_hi_d[i] = '0;
              res_lo_d[i] = '0;
              to_d[i]     = 1'b1;
            end
          end
          idx_d = idx_q + 1'b1;
        end else if (state_q == S_ARM) begin
          if (rise) seg_d = CW'(1);
        end else if (fall) begin
          acc_hi_d = acc_hi_q + AW'(seg_q);
          seg_d    = CW'(1);
        end else if (rise) begin
          acc_lo_d = acc_lo_q + AW'(seg_q);
          seg_d    = CW'(1);
          pcnt_d   = pcnt_q + 1'b1;
        end else begin
          seg_d = (&seg_q) ? seg_q : seg_q + 1'b1;
        end
      end
      S_STORE: begin
        for (int i = 0; i < 3; i++) begin
          if (idx_q == 2'(i)) begin
            res_hi_d[i] = CW'(acc_hi_q >> SH);
            res_lo_d[i] = CW'(acc_lo_q >> SH);
          end
        end
        idx_d = idx_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.busy = (state_q != S_IDLE) && (state_q != S_DONE);
    bus.done = (state_q == S_DONE);
  end

  assign bus.red_high      = res_hi_q[0];
  assign bus.red_low       = res_lo_q[0];
  assign bus.green_high    = res_hi_q[1];
  assign bus.green_low     = res_lo_q[1];
  assign bus.blue_high     = res_hi_q[2];
  assign bus.blue_low      = res_lo_q[2];
  assign bus.timeout_flags = to_q;

endmodule

// File: tb/tb_pwm_sched.sv
// Directed bench for pwm_sched: waveform generators per channel, an averaging
// model of the expected results, and a per-cycle output monitor.
module tb_pwm_sched;
  localparam int N  = 4;
  localparam int TO = 1000;
  localparam int CW = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic red   = 1'b0;
  logic green = 1'b0;
  logic blue  = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  int cyc     = 0;

  // mode: 0 = constant low, 1 = constant high, 2 = pattern hi[k]/lo[k]
  int mode [3];
  int hi   [3][2];
  int lo   [3][2];

  logic [63:0] pub  [3];
  logic [63:0] nxt  [3];
  int          stamp[3];
  logic [2:0]  exp_to = 3'b000;
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;

  pwm_sched_if #(.CW(CW)) bus ();

  pwm_sched #(.NUM_PERIODS(N), .TIMEOUT(TO), .CW(CW)) dut (
    .clk  (clk),
    .reset(reset),
    .red  (red),
    .green(green),
    .blue (blue),
    .bus  (bus)
  );

  initial forever begin
    if (mode[0] == 2) begin
      for (int k = 0; k < 2; k++) begin
        red = 1'b1; repeat (hi[0][k]) @(negedge clk);
        red = 1'b0; repeat (lo[0][k]) @(negedge clk);
      end
    end else begin
      red = (mode[0] == 1); @(negedge clk);
    end
  end

  initial forever begin
    if (mode[1] == 2) begin
      for (int k = 0; k < 2; k++) begin
        green = 1'b1; repeat (hi[1][k]) @(negedge clk);
        green = 1'b0; repeat (lo[1][k]) @(negedge clk);
      end
    end else begin
      green = (mode[1] == 1); @(negedge clk);
    end
  end

  initial forever begin
    if (mode[2] == 2) begin
      for (int k = 0; k < 2; k++) begin
        blue = 1'b1; repeat (hi[2][k]) @(negedge clk);
        blue = 1'b0; repeat (lo[2][k]) @(negedge clk);
      end
    end else begin
      blue = (mode[2] == 1); @(negedge clk);
    end
  end

  // Average of N consecutive periods of the repeating pattern; a channel with
  // no edges times out and publishes zero.
  function automatic logic [63:0] exp_res(int c);
    int sh = 0;
    int sl = 0;
    if (mode[c] != 2) return 64'd0;
    for (int k = 0; k < N; k++) begin
      sh += hi[c][k % 2];
      sl += lo[c][k % 2];
    end
    return {CW'(sh / N), CW'(sl / N)};
  endfunction

  function automatic logic [63:0] res(int c);
    case (c)
      0:       return {bus.red_high, bus.red_low};
      1:       return {bus.green_high, bus.green_low};
      default: return {bus.blue_high, bus.blue_low};
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Every cycle each channel's result pair must be either its pre-sequence
  // value or its newly expected value.
  initial begin
    logic [63:0] r;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.done) n_done++;
      if (mon_en) begin
        chk("done_busy_excl", 64'(bus.done & bus.busy), 64'd0);
        for (int c = 0; c < 3; c++) begin
          r = res(c);
          if (r == nxt[c]) chk($sformatf("mon_ch%0d", c), r, nxt[c]);
          else             chk($sformatf("mon_ch%0d", c), r, pub[c]);
          if (stamp[c] < 0 && r == nxt[c] && r != pub[c]) stamp[c] = cyc;
        end
      end
    end
  end

  task automatic start_seq(input logic [2:0] en);
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      nxt[c]   = en[c] ? exp_res(c) : pub[c];
      stamp[c] = -1;
    end
    exp_to      = en & {mode[2] != 2, mode[1] != 2, mode[0] != 2};
    bus.chan_en = en;
    bus.start   = 1'b1;
    mon_en      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", 64'(bus.busy), 64'd1);
    chk("no_early_done", 64'(bus.done), 64'd0);
  endtask

  task automatic wait_done(input bit inject);
    bit seen = 1'b0;
    int n0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk);
      if (inject && i == 20) begin
        bus.chan_en = 3'b001;
        bus.start   = 1'b1;
      end
      if (inject && i == 21) bus.start = 1'b0;
      seen = bus.done;
    end
    chk("done_seen", 64'(seen), 64'd1);
    chk("busy_low_at_done", 64'(bus.busy), 64'd0);
    chk("flags_at_done", 64'(bus.timeout_flags), 64'(exp_to));
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("result_ch%0d", c), res(c), nxt[c]);
      pub[c] = nxt[c];
    end
    @(negedge clk);
    chk("done_one_cycle", 64'(bus.done), 64'd0);
    n0 = n_done;
    repeat (30) @(negedge clk);
    chk("single_done", 64'(n_done - n0), 64'd0);
  endtask

  initial begin
    #800000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int n0;
    mode = '{2, 2, 2};
    hi   = '{'{10, 10}, '{40, 40}, '{3, 3}};
    lo   = '{'{15, 15}, '{60, 60}, '{5, 5}};
    bus.start   = 1'b0;
    bus.chan_en = 3'b000;
    for (int c = 0; c < 3; c++) begin
      pub[c]   = '0;
      nxt[c]   = '0;
      stamp[c] = -1;
    end

    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_flags", 64'(bus.timeout_flags), 64'd0);
    for (int c = 0; c < 3; c++) chk($sformatf("rst_res_ch%0d", c), res(c), 64'd0);
    reset = 1'b0;
    repeat (250) @(negedge clk);

    // red only, steady 10/15
    start_seq(3'b001);
    wait_done(1'b0);
    chk("lit_red_high", 64'(bus.red_high), 64'd10);
    chk("lit_red_low", 64'(bus.red_low), 64'd15);
    chk("lit_green_untouched", 64'(bus.green_high), 64'd0);
    chk("lit_blue_untouched", 64'(bus.blue_low), 64'd0);

    // all channels, red highs alternating 10/12
    hi[0] = '{10, 12};
    repeat (250) @(negedge clk);
    start_seq(3'b111);
    wait_done(1'b0);
    chk("lit_red_high_avg", 64'(bus.red_high), 64'd11);
    chk("lit_green_high", 64'(bus.green_high), 64'd40);
    chk("lit_green_low", 64'(bus.green_low), 64'd60);
    chk("lit_blue_high", 64'(bus.blue_high), 64'd3);
    chk("lit_blue_low", 64'(bus.blue_low), 64'd5);
    chk("order_red_green", 64'(stamp[0] >= 0 && stamp[0] < stamp[1]), 64'd1);
    chk("order_green_blue", 64'(stamp[1] >= 0 && stamp[1] < stamp[2]), 64'd1);

    // green stuck high -> watchdog
    mode[1] = 1;
    repeat (250) @(negedge clk);
    start_seq(3'b111);
    wait_done(1'b0);
    chk("lit_flags_010", 64'(bus.timeout_flags), 64'd2);
    chk("lit_green_to_zero", {bus.green_high, bus.green_low}, 64'd0);
    chk("lit_red_after_to", 64'(bus.red_high), 64'd11);
    chk("lit_blue_after_to", 64'(bus.blue_high), 64'd3);

    // second start while busy is ignored
    mode[1] = 2;
    repeat (250) @(negedge clk);
    start_seq(3'b111);
    wait_done(1'b1);
    bus.chan_en = 3'b000;
    chk("lit_green_restored", 64'(bus.green_high), 64'd40);
    chk("lit_flags_clear", 64'(bus.timeout_flags), 64'd0);

    // reset mid-MEASURE on blue
    hi[2] = '{4, 4};
    lo[2] = '{6, 6};
    repeat (250) @(negedge clk);
    start_seq(3'b100);
    repeat (18) @(negedge clk);
    mon_en = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_done", 64'(bus.done), 64'd0);
    chk("mid_rst_flags", 64'(bus.timeout_flags), 64'd0);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("mid_rst_res_ch%0d", c), res(c), 64'd0);
      pub[c] = '0;
      nxt[c] = '0;
    end
    n0 = n_done;
    repeat (40) @(negedge clk);
    chk("no_done_after_rst", 64'(n_done - n0), 64'd0);
    start_seq(3'b100);
    wait_done(1'b0);
    chk("lit_blue_high_fresh", 64'(bus.blue_high), 64'd4);
    chk("lit_blue_low_fresh", 64'(bus.blue_low), 64'd6);

    // empty enable: done at T+2, nothing changes
    start_seq(3'b000);
    @(negedge clk);
    chk("empty_done_t2", 64'(bus.done), 64'd1);
    chk("empty_busy_t2", 64'(bus.busy), 64'd0);
    @(negedge clk);
    chk("empty_done_t3", 64'(bus.done), 64'd0);
    for (int c = 0; c < 3; c++) chk($sformatf("empty_res_ch%0d", c), res(c), pub[c]);
    chk("empty_flags", 64'(bus.timeout_flags), 64'd0);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
